rtype_issue_ctrl: RTL and testbench
===================================

// Module: rtype_issue_ctrl
// PURPOSE
//  Upstream control stage for RF_ALU. It buffers LEGv8 R-format instructions and
//  decodes each one into ALUOp, OpcodeField, Read1, Read2 and WriteReg. It then
//  sequences a one-cycle RegWrite pulse. It also latches RF_ALU's zero result.
//  This replaces hand-driven RF_ALU stimulus with an instruction stream.
// PARAMETERS
//  DEPTH          4   instruction FIFO entries; power of 2, >=2
//  SETTLE_CYCLES  1   cycles in EXEC (operands stable before write); >=1
//  CNT_W          16  width of retired_count
// PORTS
//  clock          in   1      rising-edge clock shared with RF_ALU
//  reset_n        in   1      synchronous, active-low reset
//  instr          in   32     R-format: [31:21] opcode, [20:16] Rm, [9:5] Rn, [4:0] Rd
//  instr_valid    in   1      instr is valid this cycle
//  instr_ready    out  1      FIFO can accept; push = instr_valid & instr_ready
//  zero           in   1      zero flag from RF_ALU
//  ALUOp          out  2      to RF_ALU; 2'b10 for all issued R-type ops
//  OpcodeField    out  11     to RF_ALU; instr[31:21]
//  Read1          out  5      to RF_ALU; Rn
//  Read2          out  5      to RF_ALU; Rm
//  WriteReg       out  5      to RF_ALU; Rd
//  RegWrite       out  1      to RF_ALU; one-cycle write strobe
//  zero_flag      out  1      zero sampled at the last completed instruction
//  illegal        out  1      one-cycle pulse for a dropped unsupported opcode
//  busy           out  1      FIFO non-empty or state != IDLE
//  retired_count  out  CNT_W  count of completed legal instructions; wraps to 0
// BEHAVIOUR
//  - All outputs are registered except instr_ready (= !full & reset_n) and busy.
//  - Reset (reset_n=0 at an edge):
//    - FIFO empties; state goes to IDLE.
//    - Every output goes to 0, including ALUOp, RegWrite and counters.
//    - Reset mid-operation abandons the instruction; RegWrite is 0 from the next edge.
//  - FIFO:
//    - Push and pop may happen in the same cycle.
//    - When full, instr_ready=0 and instr is ignored.
//    - Pointers wrap modulo DEPTH.
//  - Legal opcodes: AND 10001010000, ORR 10101010000, ADD 10001011000, SUB 11001011000.
//  - FSM:
//    - IDLE: if FIFO is non-empty, pop the head and decode it.
//      - Legal: load ALUOp=10, OpcodeField, Read1=Rn, Read2=Rm, WriteReg=Rd; go to EXEC.
//      - Illegal: pulse illegal the next cycle; stay in IDLE; RF_ALU outputs are unchanged.
//    - EXEC: hold outputs for SETTLE_CYCLES cycles, then go to WB.
//    - WB: one cycle.
//      - RegWrite=1, unless Rd==31 (XZR), in which case the write is suppressed.
//      - zero_flag <= zero; retired_count++ (Rd==31 included).
//      - Next state is IDLE.
//  - Outside WB, RegWrite=0. ALUOp, OpcodeField, Read1, Read2 and WriteReg hold their
//    last values in IDLE.
//  - Latency with default parameters:
//    - Push at edge N: pop at N+1, EXEC at N+2, WB (RegWrite high) at N+3.
//    - Throughput is 1 instruction per 2+SETTLE_CYCLES cycles.
//  - shamt [15:10] is ignored.
// TESTING
//  - Reset: hold reset_n=0 for 2 cycles with instr_valid=1 -> all outputs 0,
//    instr_ready=0, no push.
//  - Push ADD X3,X5,X10 (0x8B0A00A3):
//    - Read1=5, Read2=10, OpcodeField=0x458, ALUOp=2'b10.
//    - RegWrite=1 for one cycle with WriteReg=3; retired_count=1.
//  - Stream AND 0x8A0A00A1, ORR 0xAA0A00A2, ADD 0x8B0A00A3, SUB 0xCB0A00A4, AND 0x8A0A00A1
//    back-to-back, DEPTH=4:
//    - instr_ready drops while full.
//    - WriteReg strobes 1,2,3,4,1 in order, 3 cycles apart; retired_count=5.
//  - MUL opcode 0x9B0A00A3: illegal pulses for 1 cycle, no RegWrite, retired_count unchanged.
//  - ADD XZR 0x8B0A00BF with zero=1: RegWrite stays 0, zero_flag=1, retired_count increments.
//  - reset_n=0 during EXEC of SUB: no RegWrite pulse, busy=0 and FIFO empty after the edge.

Source files
------------

// File: rtl/rtype_issue_ctrl.sv
// Purpose : buffers LEGv8 R-format instructions, decodes them for RF_ALU and issues a RegWrite strobe.
// Latency : push at edge N -> pop/decode at N+1 -> EXEC -> RegWrite high in the WB cycle (sampled by RF_ALU at N+3).
// Backpr. : instr_ready = !full & reset_n; a full FIFO ignores instr. Throughput is one instruction per 2+SETTLE_CYCLES cycles.
//
// Ports:
//   clock, reset_n       shared RF_ALU clock; synchronous active-low reset
//   instr/instr_valid    R-format instruction input, pushed when instr_valid & instr_ready
//   instr_ready          FIFO can accept
//   zero                 RF_ALU zero result, sampled in WB
//   ALUOp, OpcodeField,  registered RF_ALU controls, held between instructions
//   Read1, Read2, WriteReg
//   RegWrite             one-cycle write strobe (suppressed for Rd == XZR)
//   zero_flag            zero sampled at the last completed instruction
//   illegal              one-cycle pulse when an unsupported opcode is dropped
//   busy                 FIFO non-empty or FSM not idle
//   retired_count        completed legal instructions, wrapping
module rtype_issue_ctrl #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             zero,
  output logic [1:0]       ALUOp,
  output logic [10:0]      OpcodeField,
  output logic [4:0]       Read1,
  output logic [4:0]       Read2,
  output logic [4:0]       WriteReg,
  output logic             RegWrite,
  output logic             zero_flag,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  // Entries keep only {opcode, Rm, Rn, Rd}; shamt is dropped at the input.
  logic [25:0]   r_mem [DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic [SW-1:0] r_settle;
  state_t        r_state;
  state_t        w_state_nxt;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_load;
  logic        w_drop;
  logic        w_wb;
  logic        w_legal;
  logic [25:0] w_head;
  logic [10:0] w_op;
  logic [4:0]  w_rm;
  logic [4:0]  w_rn;
  logic [4:0]  w_rd;
  logic        w_unused_shamt;

  assign w_unused_shamt = ^instr[15:10];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty     = (r_wp == r_rp);
  assign w_full      = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign instr_ready = !w_full && reset_n;
  assign w_push      = instr_valid && instr_ready;
  assign busy        = !w_empty || (r_state != S_IDLE);

  assign w_head = r_mem[r_rp[AW-1:0]];
  assign w_op   = w_head[25:15];
  assign w_rm   = w_head[14:10];
  assign w_rn   = w_head[9:5];
  assign w_rd   = w_head[4:0];

  assign w_legal = (w_op == OP_AND) || (w_op == OP_ORR) ||
                   (w_op == OP_ADD) || (w_op == OP_SUB);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_legal) begin
            w_load      = 1'b1;
            w_state_nxt = S_EXEC;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (r_settle == SETTLE_LAST) w_state_nxt = S_WB;
      end
      S_WB: begin
        w_wb        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {instr[31:21], instr[20:16], instr[9:5], instr[4:0]};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wp          <= '0;
      r_rp          <= '0;
      r_settle      <= '0;
      ALUOp         <= '0;
      OpcodeField   <= '0;
      Read1         <= '0;
      Read2         <= '0;
      WriteReg      <= '0;
      RegWrite      <= 1'b0;
      zero_flag     <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;

      if (w_load)                 r_settle <= '0;
      else if (r_state == S_EXEC) r_settle <= r_settle + 1'b1;

      if (w_load) begin
        ALUOp       <= 2'b10;
        OpcodeField <= w_op;
        Read1       <= w_rn;
        Read2       <= w_rm;
        WriteReg    <= w_rd;
      end

      illegal <= w_drop;

      // Raised on the EXEC->WB transition so the strobe coincides with the WB cycle.
      RegWrite <= (r_state == S_EXEC) && (w_state_nxt == S_WB) && (WriteReg != 5'd31);

      if (w_wb) begin
        zero_flag     <= zero;
        retired_count <= retired_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
module tb_rtype_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        zero;
  logic [1:0]  ALUOp;
  logic [10:0] OpcodeField;
  logic [4:0]  Read1;
  logic [4:0]  Read2;
  logic [4:0]  WriteReg;
  logic        RegWrite;
  logic        zero_flag;
  logic        illegal;
  logic        busy;
  logic [15:0] retired_count;

  always #5 clock = ~clock;

  rtype_issue_ctrl #(.DEPTH(4), .SETTLE_CYCLES(1), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero(zero), .ALUOp(ALUOp), .OpcodeField(OpcodeField),
    .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .zero_flag(zero_flag), .illegal(illegal), .busy(busy), .retired_count(retired_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        legal;
    logic [10:0] op;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
    logic        rw;
  } vec_t;

  vec_t vt[7];

  // Expected state of the held outputs
  logic [1:0]  e_alu;
  logic [10:0] e_op;
  logic [4:0]  e_rn, e_rm, e_rd;
  logic        e_zf;
  logic [15:0] e_ret;

  task automatic run_one(input vec_t v);
    instr       = v.instr;
    zero        = v.zero;
    instr_valid = 1'b1;
    chk("ready_when_idle", instr_ready, 1);
    step();                       // push
    instr_valid = 1'b0;
    chk("busy_after_push", busy, 1);
    step();                       // pop + decode
    if (v.legal) begin
      e_alu = 2'b10; e_op = v.op; e_rn = v.rn; e_rm = v.rm; e_rd = v.rd;
      chk("illegal_low", illegal, 0);
    end else begin
      chk("illegal_pulse", illegal, 1);
    end
    chk("ALUOp", ALUOp, e_alu);
    chk("OpcodeField", OpcodeField, e_op);
    chk("Read1", Read1, e_rn);
    chk("Read2", Read2, e_rm);
    chk("WriteReg", WriteReg, e_rd);
    chk("RegWrite_exec", RegWrite, 0);
    if (v.legal) begin
      step();                     // WB cycle
      chk("RegWrite_wb", RegWrite, v.rw);
      chk("WriteReg_wb", WriteReg, e_rd);
      chk("retired_before_wb", retired_count, e_ret);
      step();
      e_zf  = v.zero;
      e_ret = e_ret + 16'd1;
      chk("RegWrite_after", RegWrite, 0);
    end else begin
      step();
      chk("illegal_one_cycle", illegal, 0);
      chk("RegWrite_illegal", RegWrite, 0);
    end
    chk("zero_flag", zero_flag, e_zf);
    chk("retired_count", retired_count, e_ret);
    chk("busy_idle", busy, 0);
  endtask

  logic [31:0] st[7];
  logic [4:0]  st_rd[7];

  initial begin
    // Directed single-instruction vectors: instr, zero, legal, opcode, Rn, Rm, Rd, RegWrite
    vt[0] = '{32'h8B0A00A3, 1'b0, 1'b1, 11'h458, 5'd5,  5'd10, 5'd3,  1'b1}; // ADD X3,X5,X10
    vt[1] = '{32'h9B0A00A3, 1'b1, 1'b0, 11'h000, 5'd0,  5'd0,  5'd0,  1'b0}; // MUL: dropped
    vt[2] = '{32'h8B0A00BF, 1'b1, 1'b1, 11'h458, 5'd5,  5'd10, 5'd31, 1'b0}; // ADD XZR
    vt[3] = '{32'hAA0A00A2, 1'b0, 1'b1, 11'h550, 5'd5,  5'd10, 5'd2,  1'b1}; // ORR
    vt[4] = '{32'hCB0A00A4, 1'b1, 1'b1, 11'h658, 5'd5,  5'd10, 5'd4,  1'b1}; // SUB
    vt[5] = '{32'h8A0A00A1, 1'b0, 1'b1, 11'h450, 5'd5,  5'd10, 5'd1,  1'b1}; // AND
    vt[6] = '{{11'h658, 5'd25, 6'd5, 5'd12, 5'd7}, 1'b0, 1'b1, 11'h658, 5'd12, 5'd25, 5'd7, 1'b1}; // SUB, shamt!=0

    st[0] = 32'h8A0A00A1; st_rd[0] = 5'd1;
    st[1] = 32'hAA0A00A2; st_rd[1] = 5'd2;
    st[2] = 32'h8B0A00A3; st_rd[2] = 5'd3;
    st[3] = 32'hCB0A00A4; st_rd[3] = 5'd4;
    st[4] = 32'h8A0A00A1; st_rd[4] = 5'd1;
    st[5] = 32'h8B0A00A3; st_rd[5] = 5'd3;
    st[6] = 32'hCB0A00A4; st_rd[6] = 5'd4;

    // Reset held two cycles with instr_valid asserted
    reset_n = 1'b0; instr_valid = 1'b1; instr = 32'h8B0A00A3; zero = 1'b0;
    step();
    step();
    chk("rst_ready", instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ALUOp", ALUOp, 0);
    chk("rst_OpcodeField", OpcodeField, 0);
    chk("rst_Read1", Read1, 0);
    chk("rst_Read2", Read2, 0);
    chk("rst_WriteReg", WriteReg, 0);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_zero_flag", zero_flag, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retired", retired_count, 0);
    reset_n = 1'b1; instr_valid = 1'b0;
    step();
    chk("post_rst_no_push", busy, 0);
    chk("post_rst_ready", instr_ready, 1);

    e_alu = '0; e_op = '0; e_rn = '0; e_rm = '0; e_rd = '0; e_zf = 1'b0; e_ret = '0;
    for (int i = 0; i < 7; i++) run_one(vt[i]);

    // Back-to-back stream that fills the FIFO
    begin
      int  k;
      int  nstrobe;
      int  last;
      logic saw_full;
      logic rdy;
      k = 0; nstrobe = 0; last = 0; saw_full = 1'b0; zero = 1'b0;
      for (int c = 0; c < 80 && nstrobe < 7; c++) begin
        instr_valid = (k < 7);
        instr       = st[(k < 7) ? k : 0];
        rdy         = instr_ready;
        if (!rdy) saw_full = 1'b1;
        step();
        if (instr_valid && rdy) k++;
        if (RegWrite) begin
          chk("stream_rd", WriteReg, st_rd[nstrobe]);
          if (nstrobe > 0) chk("stream_gap", c - last, 3);
          last = c;
          nstrobe++;
        end
      end
      instr_valid = 1'b0;
      chk("stream_strobes", nstrobe, 7);
      chk("stream_ready_dropped", saw_full, 1);
      step();
      e_ret = e_ret + 16'd7;
      chk("stream_retired", retired_count, e_ret);
      chk("stream_busy", busy, 0);
    end

    // Reset during EXEC of SUB abandons the instruction
    instr = 32'hCB0A00A4; instr_valid = 1'b1; zero = 1'b0;
    step();
    instr_valid = 1'b0;
    step();
    chk("exec_busy", busy, 1);
    reset_n = 1'b0;
    step();
    chk("midrst_RegWrite", RegWrite, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", instr_ready, 0);
    chk("midrst_retired", retired_count, 0);
    chk("midrst_WriteReg", WriteReg, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_RegWrite", RegWrite, 0);
      chk("postrst_busy", busy, 0);
    end
    chk("postrst_ready", instr_ready, 1);
    chk("postrst_retired", retired_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
